banco_ativos: RTL
=================

# banco_ativos

Register bank for the active-node (NA) slots of the path-search engine; the write-side responder to `gerenciador_ativos`. It applies the one-hot update/deactivate commands issued by the manager and stores, per slot, node address, predecessor address, path cost and active flag. It feeds slot addresses and active flags back to the manager. On request, a sequential scan returns the lowest-cost active slot to the search controller.

## Interface
- `NUM_NA`, 8: number of slots, ≥2.
- `ADR_WIDTH`, 5: node address width.
- `CUSTO_WIDTH`, 8: path cost width, unsigned.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: synchronous active-high reset.
- `ga_atualizar_in` input 1: update command level.
- `ga_desativar_in` input 1: deactivate command level.
- `ga_habilitar_in` input NUM_NA: slot select; a write happens only in cycles where this is nonzero.
- `ga_endereco_in` input ADR_WIDTH: node address to store.
- `ga_anterior_in` input ADR_WIDTH: predecessor address to store.
- `custo_in` input CUSTO_WIDTH: cost to store.
- `na_endereco_out` output ADR_WIDTH*NUM_NA: packed slot addresses, slot i at bits [ADR_WIDTH*i +: ADR_WIDTH].
- `na_ativo_out` output NUM_NA: slot active flags.
- `menor_req_in` input 1: start minimum scan; single-cycle pulse.
- `menor_pronto_out` output 1: one-cycle pulse, scan result valid.
- `menor_valido_out` output 1: at least one active slot was found; held until the next pronto.
- `menor_indice_out` output $clog2(NUM_NA): winning slot index.
- `menor_endereco_out`, `menor_anterior_out` output ADR_WIDTH: winning slot contents.
- `menor_custo_out` output CUSTO_WIDTH: winning slot cost.

## Operation
**Slot writes.** Evaluated per slot i with `ga_habilitar_in[i]`=1, in the same cycle.
- `ga_desativar_in`=1: ativo[i] ← 0. Address, predecessor and cost are retained. Deactivate has priority over update when both are high.
- `ga_atualizar_in`=1 and ativo[i]=0: write address, predecessor and cost; ativo[i] ← 1.
- `ga_atualizar_in`=1 and ativo[i]=1: write only if `custo_in` < stored cost (strict less-than; this is the relaxation rule). Otherwise there is no change.
- Multi-hot select applies the rule to every selected slot. Zero select, or both command levels low, means no write.

**Scan FSM.** States `ST_IDLE`, `ST_BUSCA`, `ST_FIM`.
- `ST_IDLE`: when `menor_req_in`=1, clear the index counter and best-found flag, then go to `ST_BUSCA`.
- `ST_BUSCA`: one slot per cycle, index 0..NUM_NA-1.
  - If the slot is active and (no best yet, or cost < best cost), capture index, address, predecessor and cost.
  - On a tie the lower index wins.
  - At index NUM_NA-1 go to `ST_FIM`; otherwise increment the counter.
- `ST_FIM`: drive the result registers, pulse `menor_pronto_out`, go to `ST_IDLE`.
- `menor_req_in` outside `ST_IDLE` is ignored (not queued).
- Each slot is sampled in its scan cycle using the pre-write register value. Writes to slots already scanned are not reflected in the result.
- No active slot: `menor_valido_out`=0; index, address, predecessor and cost outputs are 0.

## Timing
- Reset: every slot field is 0 and all ativo bits are 0. `na_endereco_out`=0, `na_ativo_out`=0. FSM is in `ST_IDLE`. All `menor_*` outputs are 0.
- Reset mid-scan aborts the scan; no pronto is produced.
- Slot write is visible on `na_*_out` one cycle after the command cycle. These outputs are direct register outputs with no extra stage.
- Scan latency: req sampled at edge t, slots scanned at edges t+1..t+NUM_NA, `menor_pronto_out` high during cycle t+NUM_NA+1.
- The result outputs are updated on the same edge pronto rises and hold until the next pronto.
- The earliest accepted next req is the cycle after pronto.

## Structure
- Package `banco_ativos_pkg` holds:
  - FSM state encoding (2 bits).
  - Index width function, clog2 of NUM_NA.
  - A slot record typedef: endereco, anterior, custo, ativo.
- One sub-module, `busca_menor`. It contains the scan FSM, index counter and best-so-far registers, and reads the slot array through packed ports. The top level holds the slot array and the write logic.

## Test plan
- Reset, then update slot 2 with addr 5, prev 1, cost 10 → next cycle `na_ativo_out`=0x04 and slot 2 address field = 5.
- Slot 2 active at cost 10; update with cost 12 → unchanged. Update with cost 7, prev 3 → cost 7, prev 3. Update with cost 7 again → unchanged (strict less-than).
- Slots 1 and 6 active at cost 4, slot 3 at cost 9; req → pronto exactly NUM_NA+1 cycles after req, index 1, cost 4, valido=1.
- All slots inactive; req → pronto with valido=0 and all result outputs 0.
- Both commands high with habilitar=0x08 on active slot 3 → ativo[3]=0 and the stored fields are unchanged. Second req during a scan → ignored, exactly one pronto.
- Slot 0 active at cost 20; req; at the scan cycle of index 5, write slot 0 to cost 1 and activate slot 7 at cost 2 → result index 7, cost 2.
- Assert `rst` during `ST_BUSCA` → no pronto, all outputs 0 the next cycle.

Source files
------------

// File: rtl/banco_ativos_pkg.sv
// Shared types for the active-node register bank: scan FSM encoding,
// index width helper and the per-slot record layout.
package banco_ativos_pkg;

    localparam int NUM_NA_DEF      = 8;
    localparam int ADR_WIDTH_DEF   = 5;
    localparam int CUSTO_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSCA = 2'd1,
        ST_FIM   = 2'd2
    } estado_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [ADR_WIDTH_DEF-1:0]   endereco;
        logic [ADR_WIDTH_DEF-1:0]   anterior;
        logic [CUSTO_WIDTH_DEF-1:0] custo;
        logic                       ativo;
    } slot_t;

endpackage

// File: rtl/banco_ativos_busca_menor.sv
// Sequential minimum-cost scan over the slot array, one slot per cycle,
// with registered result outputs and a one-cycle ready pulse.
module busca_menor
    import banco_ativos_pkg::*;
#(
    parameter  int NUM_NA      = NUM_NA_DEF,
    parameter  int ADR_WIDTH   = ADR_WIDTH_DEF,
    parameter  int CUSTO_WIDTH = CUSTO_WIDTH_DEF,
    localparam int IDX_W       = idx_width(NUM_NA)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_in,
    input  logic [NUM_NA-1:0]                     ativo_in,
    input  logic [NUM_NA-1:0][ADR_WIDTH-1:0]      endereco_in,
    input  logic [NUM_NA-1:0][ADR_WIDTH-1:0]      anterior_in,
    input  logic [NUM_NA-1:0][CUSTO_WIDTH-1:0]    custo_in,
    output logic                                  pronto_out,
    output logic                                  valido_out,
    output logic [IDX_W-1:0]                      indice_out,
    output logic [ADR_WIDTH-1:0]                  endereco_out,
    output logic [ADR_WIDTH-1:0]                  anterior_out,
    output logic [CUSTO_WIDTH-1:0]                custo_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NA - 1);

    estado_t                state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   achou_q, achou_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic [ADR_WIDTH-1:0]   best_end_q, best_end_d;
    logic [ADR_WIDTH-1:0]   best_ant_q, best_ant_d;
    logic [CUSTO_WIDTH-1:0] best_custo_q, best_custo_d;
    logic                   pronto_q, pronto_d;
    logic                   valido_q, valido_d;
    logic [IDX_W-1:0]       res_idx_q, res_idx_d;
    logic [ADR_WIDTH-1:0]   res_end_q, res_end_d;
    logic [ADR_WIDTH-1:0]   res_ant_q, res_ant_d;
    logic [CUSTO_WIDTH-1:0] res_custo_q, res_custo_d;

    // Scan next-state and best-so-far / result update
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        achou_d      = achou_q;
        best_idx_d   = best_idx_q;
        best_end_d   = best_end_q;
        best_ant_d   = best_ant_q;
        best_custo_d = best_custo_q;
        pronto_d     = 1'b0;
        valido_d     = valido_q;
        res_idx_d    = res_idx_q;
        res_end_d    = res_end_q;
        res_ant_d    = res_ant_q;
        res_custo_d  = res_custo_q;
        case (state_q)
            ST_IDLE: begin
                // a req landing on the pronto cycle is too early and is dropped
                if (req_in && !pronto_q) begin
                    state_d      = ST_BUSCA;
                    idx_d        = {IDX_W{1'b0}};
                    achou_d      = 1'b0;
                    best_idx_d   = {IDX_W{1'b0}};
                    best_end_d   = {ADR_WIDTH{1'b0}};
                    best_ant_d   = {ADR_WIDTH{1'b0}};
                    best_custo_d = {CUSTO_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSCA: begin
                if (ativo_in[idx_q] && (!achou_q || (custo_in[idx_q] < best_custo_q))) begin
                    achou_d      = 1'b1;
                    best_idx_d   = idx_q;
                    best_end_d   = endereco_in[idx_q];
                    best_ant_d   = anterior_in[idx_q];
                    best_custo_d = custo_in[idx_q];
                end else begin
                    achou_d = achou_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FIM;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FIM: begin
                pronto_d    = 1'b1;
                valido_d    = achou_q;
                res_idx_d   = best_idx_q;
                res_end_d   = best_end_q;
                res_ant_d   = best_ant_q;
                res_custo_d = best_custo_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan state, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IDX_W{1'b0}};
            achou_q      <= 1'b0;
            best_idx_q   <= {IDX_W{1'b0}};
            best_end_q   <= {ADR_WIDTH{1'b0}};
            best_ant_q   <= {ADR_WIDTH{1'b0}};
            best_custo_q <= {CUSTO_WIDTH{1'b0}};
            pronto_q     <= 1'b0;
            valido_q     <= 1'b0;
            res_idx_q    <= {IDX_W{1'b0}};
            res_end_q    <= {ADR_WIDTH{1'b0}};
            res_ant_q    <= {ADR_WIDTH{1'b0}};
            res_custo_q  <= {CUSTO_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            achou_q      <= achou_d;
            best_idx_q   <= best_idx_d;
            best_end_q   <= best_end_d;
            best_ant_q   <= best_ant_d;
            best_custo_q <= best_custo_d;
            pronto_q     <= pronto_d;
            valido_q     <= valido_d;
            res_idx_q    <= res_idx_d;
            res_end_q    <= res_end_d;
            res_ant_q    <= res_ant_d;
            res_custo_q  <= res_custo_d;
        end
    end

    assign pronto_out   = pronto_q;
    assign valido_out   = valido_q;
    assign indice_out   = res_idx_q;
    assign endereco_out = res_end_q;
    assign anterior_out = res_ant_q;
    assign custo_out    = res_custo_q;

endmodule

// File: rtl/banco_ativos.sv
// Active-node slot register bank: applies manager update/deactivate commands
// with the relaxation rule and hosts the lowest-cost scan.
module banco_ativos
    import banco_ativos_pkg::*;
#(
    parameter int NUM_NA      = NUM_NA_DEF,
    parameter int ADR_WIDTH   = ADR_WIDTH_DEF,
    parameter int CUSTO_WIDTH = CUSTO_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ga_atualizar_in,
    input  logic                          ga_desativar_in,
    input  logic [NUM_NA-1:0]             ga_habilitar_in,
    input  logic [ADR_WIDTH-1:0]          ga_endereco_in,
    input  logic [ADR_WIDTH-1:0]          ga_anterior_in,
    input  logic [CUSTO_WIDTH-1:0]        custo_in,
    output logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_out,
    output logic [NUM_NA-1:0]             na_ativo_out,
    input  logic                          menor_req_in,
    output logic                          menor_pronto_out,
    output logic                          menor_valido_out,
    output logic [idx_width(NUM_NA)-1:0]  menor_indice_out,
    output logic [ADR_WIDTH-1:0]          menor_endereco_out,
    output logic [ADR_WIDTH-1:0]          menor_anterior_out,
    output logic [CUSTO_WIDTH-1:0]        menor_custo_out
);

    logic [NUM_NA-1:0][ADR_WIDTH-1:0]   endereco_q, endereco_d;
    logic [NUM_NA-1:0][ADR_WIDTH-1:0]   anterior_q, anterior_d;
    logic [NUM_NA-1:0][CUSTO_WIDTH-1:0] custo_q, custo_d;
    logic [NUM_NA-1:0]                  ativo_q, ativo_d;

    // Per-slot command decode: deactivate wins, update fills or relaxes
    always_comb begin
        endereco_d = endereco_q;
        anterior_d = anterior_q;
        custo_d    = custo_q;
        ativo_d    = ativo_q;
        for (int i = 0; i < NUM_NA; i++) begin
            if (ga_habilitar_in[i]) begin
                if (ga_desativar_in) begin
                    ativo_d[i] = 1'b0;
                end else if (ga_atualizar_in && (!ativo_q[i] || (custo_in < custo_q[i]))) begin
                    endereco_d[i] = ga_endereco_in;
                    anterior_d[i] = ga_anterior_in;
                    custo_d[i]    = custo_in;
                    ativo_d[i]    = 1'b1;
                end else begin
                    ativo_d[i] = ativo_q[i];
                end
            end else begin
                ativo_d[i] = ativo_q[i];
            end
        end
    end

    // Slot storage
    always_ff @(posedge clk) begin
        if (rst) begin
            endereco_q <= {(NUM_NA*ADR_WIDTH){1'b0}};
            anterior_q <= {(NUM_NA*ADR_WIDTH){1'b0}};
            custo_q    <= {(NUM_NA*CUSTO_WIDTH){1'b0}};
            ativo_q    <= {NUM_NA{1'b0}};
        end else begin
            endereco_q <= endereco_d;
            anterior_q <= anterior_d;
            custo_q    <= custo_d;
            ativo_q    <= ativo_d;
        end
    end

    assign na_endereco_out = endereco_q;
    assign na_ativo_out    = ativo_q;

    busca_menor #(
        .NUM_NA      (NUM_NA),
        .ADR_WIDTH   (ADR_WIDTH),
        .CUSTO_WIDTH (CUSTO_WIDTH)
    ) u_busca_menor (
        .clk          (clk),
        .rst          (rst),
        .req_in       (menor_req_in),
        .ativo_in     (ativo_q),
        .endereco_in  (endereco_q),
        .anterior_in  (anterior_q),
        .custo_in     (custo_q),
        .pronto_out   (menor_pronto_out),
        .valido_out   (menor_valido_out),
        .indice_out   (menor_indice_out),
        .endereco_out (menor_endereco_out),
        .anterior_out (menor_anterior_out),
        .custo_out    (menor_custo_out)
    );

endmodule
